// File: rtl/wb_decoder2_if.sv
// Wishbone bus bundle used on the master-facing and slave-facing sides of wb_decoder2.
interface wb_decoder2_if #(
    parameter int unsigned addr_width = 32,
    parameter int unsigned data_width = 32
) ();
    logic [addr_width-1:0]   adr;
    logic [data_width-1:0]   datwr;
    logic [data_width-1:0]   datrd;
    logic                    we;
    logic [data_width/8-1:0] sel;
    logic                    stb;
    logic                    cyc;
    logic                    ack;

    modport master (
        output adr, datwr, we, sel, stb, cyc,
        input  datrd, ack
    );

    modport slave (
        input  adr, datwr, we, sel, stb, cyc,
        output datrd, ack
    );
endinterface

// File: rtl/wb_decoder2.sv
// Registered 1-master / 2-slave Wishbone decoder with an ack watchdog.
// Slave 1 is the masked address window, slave 0 takes everything else.
module wb_decoder2 #(
    parameter int unsigned           addr_width     = 32,
    parameter int unsigned           data_width     = 32,
    parameter logic [addr_width-1:0] s1_base        = addr_width'(32'h8000_0000),
    parameter logic [addr_width-1:0] s1_mask        = addr_width'(32'hF000_0000),
    parameter int unsigned           timeout_cycles = 255,
    parameter logic [data_width-1:0] err_data       = data_width'(32'hDEAD_BEEF)
) (
    input  logic          clock,
    input  logic          reset,
    wb_decoder2_if.slave  wb,
    wb_decoder2_if.master s0,
    wb_decoder2_if.master s1,
    output logic          err_timeout
);
    localparam int unsigned cnt_w = $clog2(timeout_cycles + 1);
    localparam logic [cnt_w-1:0] cnt_last = cnt_w'(timeout_cycles - 1);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        BUSY = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t                state_q, state_d;
    logic [cnt_w-1:0]      cnt_q, cnt_d;
    logic                  sel_q, sel_d;
    logic                  ack_q, ack_d;
    logic                  err_q, err_d;
    logic [data_width-1:0] datrd_q, datrd_d;

    logic                  req;
    logic                  hit_s1;
    logic                  strobe_en;
    logic                  slv_ack;
    logic [data_width-1:0] slv_datrd;

    always_comb begin
        req       = wb.cyc & wb.stb;
        hit_s1    = (wb.adr & s1_mask) == s1_base;
        strobe_en = (state_q == BUSY) & req;
        slv_ack   = sel_q ? s1.ack : s0.ack;
        slv_datrd = sel_q ? s1.datrd : s0.datrd;
    end

    assign s0.adr   = wb.adr;
    assign s0.datwr = wb.datwr;
    assign s0.we    = wb.we;
    assign s0.sel   = wb.sel;
    assign s1.adr   = wb.adr;
    assign s1.datwr = wb.datwr;
    assign s1.we    = wb.we;
    assign s1.sel   = wb.sel;

    // Strobes follow the live master request so an abort drops them in the same cycle.
    assign s0.cyc = strobe_en & ~sel_q;
    assign s0.stb = strobe_en & ~sel_q;
    assign s1.cyc = strobe_en & sel_q;
    assign s1.stb = strobe_en & sel_q;

    assign wb.ack      = ack_q;
    assign wb.datrd    = datrd_q;
    assign err_timeout = err_q;

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        sel_d   = sel_q;
        datrd_d = datrd_q;
        ack_d   = 1'b0;
        err_d   = 1'b0;
        unique case (state_q)
            IDLE: begin
                if (req) begin
                    sel_d   = hit_s1;
                    cnt_d   = '0;
                    state_d = BUSY;
                end
            end
            BUSY: begin
                // Priority: abort, then slave ack, then watchdog expiry.
                if (!req) begin
                    state_d = IDLE;
                end else if (slv_ack) begin
                    ack_d   = 1'b1;
                    if (!wb.we) datrd_d = slv_datrd;
                    state_d = DONE;
                end else if (cnt_q == cnt_last) begin
                    ack_d   = 1'b1;
                    err_d   = 1'b1;
                    if (!wb.we) datrd_d = err_data;
                    state_d = DONE;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            DONE: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge clock) begin
        if (!reset) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            sel_q   <= 1'b0;
            ack_q   <= 1'b0;
            err_q   <= 1'b0;
            datrd_q <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            sel_q   <= sel_d;
            ack_q   <= ack_d;
            err_q   <= err_d;
            datrd_q <= datrd_d;
        end
    end
endmodule

// File: tb/tb_wb_decoder2.sv
// Scoreboard bench for wb_decoder2: a driver issues transactions and queues the
// expected completion; a negedge monitor pops and compares on every wb_ack.
module tb_wb_decoder2;
    localparam int          TO    = 8;
    localparam logic [31:0] BASE  = 32'h8000_0000;
    localparam logic [31:0] MASK  = 32'hF000_0000;
    localparam logic [31:0] ERRD  = 32'hDEAD_BEEF;
    localparam int          NEVER = 100000;

    typedef struct {
        int          slv;
        logic [31:0] datrd;
        logic        err;
        int          stb_cyc;
        int          ack_cycle;
    } exp_t;

    logic clock = 1'b0;
    logic reset = 1'b0;
    logic err_timeout;

    wb_decoder2_if #(.addr_width(32), .data_width(32)) wb ();
    wb_decoder2_if #(.addr_width(32), .data_width(32)) s0 ();
    wb_decoder2_if #(.addr_width(32), .data_width(32)) s1 ();

    wb_decoder2 #(
        .addr_width    (32),
        .data_width    (32),
        .s1_base       (BASE),
        .s1_mask       (MASK),
        .timeout_cycles(TO),
        .err_data      (ERRD)
    ) dut (
        .clock      (clock),
        .reset      (reset),
        .wb         (wb),
        .s0         (s0),
        .s1         (s1),
        .err_timeout(err_timeout)
    );

    always #5 clock = ~clock;

    int tests = 0;
    int fails = 0;
    int cycle_cnt = 0;
    exp_t expq[$];

    // Slave models: ack in the (delay+1)-th strobe cycle; random ack noise while not strobed.
    int          dly0 = NEVER, dly1 = NEVER;
    int          scnt0 = 0, scnt1 = 0;
    logic [31:0] sdat0 = '0, sdat1 = '0;
    logic        noise0 = 1'b0, noise1 = 1'b0;
    logic        force0 = 1'b0, force1 = 1'b0;

    assign s0.ack   = s0.stb ? (scnt0 == dly0) : noise0;
    assign s1.ack   = s1.stb ? (scnt1 == dly1) : noise1;
    assign s0.datrd = sdat0;
    assign s1.datrd = sdat1;

    always @(posedge clock) begin
        cycle_cnt = cycle_cnt + 1;
    end

    always @(posedge clock) begin
        scnt0  <= (s0.stb && !s0.ack) ? scnt0 + 1 : 0;
        scnt1  <= (s1.stb && !s1.ack) ? scnt1 + 1 : 0;
        noise0 <= force0 | ($urandom_range(0, 3) == 0);
        noise1 <= force1 | ($urandom_range(0, 3) == 0);
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cycle_cnt);
        end
    endtask

    // Monitor
    int c0 = 0, c1 = 0;
    always @(negedge clock) begin
        exp_t e;
        if (wb.ack) begin
            if (expq.size() == 0) begin
                chk("unexpected_ack", wb.ack, 1'b0);
            end else begin
                e = expq.pop_front();
                chk("datrd", wb.datrd, e.datrd);
                chk("err_timeout", err_timeout, e.err);
                chk("stb_cycles", e.slv ? c1 : c0, e.stb_cyc);
                chk("other_stb", e.slv ? c0 : c1, 0);
                chk("ack_latency", cycle_cnt, e.ack_cycle);
            end
            c0 = 0;
            c1 = 0;
        end else begin
            if (err_timeout) chk("err_without_ack", err_timeout, wb.ack);
            if (s0.stb) c0++;
            if (s1.stb) c1++;
            if (!s0.stb && !s1.stb) begin
                c0 = 0;
                c1 = 0;
            end
        end
    end

    // Driver state: last read data seen by the master, earliest edge that can sample a request.
    logic [31:0] model_datrd = '0;
    int          min_sample  = 0;

    task automatic run_txn(input logic [31:0] adr, input logic we, input logic [31:0] dat,
                           input logic [3:0] sel, input logic [31:0] rdat, input int delay,
                           input int abort_k, input int gap);
        int   c, sample, slv, got;
        logic err;
        exp_t e;
        repeat (gap) begin
            wb.cyc = 1'b0;
            wb.stb = 1'b0;
            @(posedge clock); #1;
        end
        slv    = ((adr & MASK) == BASE) ? 1 : 0;
        c      = cycle_cnt;
        sample = (c + 1 > min_sample) ? c + 1 : min_sample;
        wb.adr = adr; wb.we = we; wb.datwr = dat; wb.sel = sel;
        wb.cyc = 1'b1; wb.stb = 1'b1;
        dly0 = delay; dly1 = delay;
        sdat0 = slv ? $urandom : rdat;
        sdat1 = slv ? rdat : $urandom;
        if (abort_k == 0) begin
            err         = (delay >= TO);
            e.slv       = slv;
            e.err       = err;
            e.stb_cyc   = err ? TO : delay + 1;
            e.ack_cycle = sample + e.stb_cyc;
            e.datrd     = we ? model_datrd : (err ? ERRD : rdat);
            model_datrd = e.datrd;
            expq.push_back(e);
        end
        #1;
        chk("bcast_adr", slv ? s1.adr : s0.adr, adr);
        chk("bcast_sel", slv ? s1.sel : s0.sel, {28'b0, sel});
        chk("bcast_datwr", slv ? s1.datwr : s0.datwr, dat);
        chk("bcast_we", slv ? s1.we : s0.we, {31'b0, we});
        if (abort_k > 0) begin
            while (cycle_cnt < sample + abort_k - 1) begin
                @(posedge clock); #1;
            end
            if ($urandom_range(0, 1) == 1) wb.cyc = 1'b0;
            else wb.stb = 1'b0;
            #1;
            chk("abort_s0_stb", s0.stb, 1'b0);
            chk("abort_s1_stb", s1.stb, 1'b0);
            wb.cyc = 1'b0;
            wb.stb = 1'b0;
            @(posedge clock); #1;
            min_sample = sample + abort_k + 1;
        end else begin
            got = 0;
            for (int i = 0; i < TO + 10; i++) begin
                @(posedge clock); #1;
                if (wb.ack) begin
                    got = 1;
                    break;
                end
            end
            if (got == 0) chk("ack_wait_expired", wb.ack, 1'b1);
            min_sample = cycle_cnt + 2;
        end
    endtask

    task automatic reset_midflight();
        repeat (2) begin
            wb.cyc = 1'b0;
            wb.stb = 1'b0;
            @(posedge clock); #1;
        end
        wb.adr = BASE; wb.we = 1'b0; wb.sel = 4'hF;
        dly0 = NEVER; dly1 = NEVER;
        wb.cyc = 1'b1; wb.stb = 1'b1;
        repeat (3) begin
            @(posedge clock); #1;
        end
        reset  = 1'b0;
        wb.cyc = 1'b0;
        wb.stb = 1'b0;
        @(posedge clock); #1;
        reset = 1'b1;
        model_datrd = '0;
        chk("rst_ack", wb.ack, 1'b0);
        chk("rst_err", err_timeout, 1'b0);
        chk("rst_datrd", wb.datrd, 32'h0);
        chk("rst_s0_stb", s0.stb, 1'b0);
        chk("rst_s1_stb", s1.stb, 1'b0);
        force1 = 1'b1;
        repeat (3) begin
            @(posedge clock); #1;
            chk("late_ack_ignored", wb.ack, 1'b0);
        end
        force1 = 1'b0;
        min_sample = 0;
    endtask

    initial begin
        logic [31:0] adr;
        int          delay, abort_k;
        wb.adr = '0; wb.datwr = '0; wb.we = 1'b0; wb.sel = '0;
        wb.cyc = 1'b0; wb.stb = 1'b0;
        reset = 1'b0;
        repeat (2) begin
            @(posedge clock); #1;
        end
        chk("reset_ack", wb.ack, 1'b0);
        chk("reset_datrd", wb.datrd, 32'h0);
        chk("reset_err", err_timeout, 1'b0);
        chk("reset_s0_stb", s0.stb, 1'b0);
        chk("reset_s1_stb", s1.stb, 1'b0);
        reset = 1'b1;
        @(posedge clock); #1;

        run_txn(32'h0000_0010, 1'b0, 32'h0, 4'hF, 32'h1234_5678, 0, 0, 0);
        run_txn(32'h8000_0004, 1'b1, 32'h0000_AB00, 4'b0010, 32'h0BAD_0BAD, 3, 0, 0);
        run_txn(32'h8000_0000, 1'b0, 32'h0, 4'hF, 32'h0BAD_0BAD, NEVER, 0, 1);
        run_txn(32'h8000_0010, 1'b0, 32'h0, 4'hF, 32'hCAFE_0001, TO - 1, 0, 0);
        run_txn(32'h0000_0100, 1'b0, 32'h0, 4'hF, 32'h0BAD_0BAD, NEVER, 2, 0);
        run_txn(32'h0000_0104, 1'b0, 32'h0, 4'hF, 32'h5555_AAAA, 1, 0, 0);
        reset_midflight();
        run_txn(32'h0000_0200, 1'b0, 32'h0, 4'hF, 32'h7777_0001, 0, 0, 0);

        for (int n = 0; n < 150; n++) begin
            if ($urandom_range(0, 1) == 1) adr = BASE | ($urandom & 32'h0FFF_FFFC);
            else adr = {4'($urandom_range(0, 15)) ^ 4'h8 ^ 4'($urandom_range(1, 15)) , 28'($urandom)};
            delay   = ($urandom_range(0, 7) == 0) ? NEVER : $urandom_range(0, TO + 2);
            abort_k = 0;
            if ($urandom_range(0, 7) == 0) begin
                abort_k = $urandom_range(1, TO);
                delay   = NEVER;
            end
            run_txn(adr, 1'($urandom), $urandom, 4'($urandom), $urandom, delay, abort_k,
                    $urandom_range(0, 2));
        end

        wb.cyc = 1'b0;
        wb.stb = 1'b0;
        repeat (5) @(posedge clock);
        #1;
        chk("queue_drained", expq.size(), 0);
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

    initial begin
        #400000;
        $display("FAIL global_timeout: simulation did not complete");
        $fatal(1, "timeout");
    end
endmodule
